// File: rtl/keypad_scanner_if.sv
// Keypad-side and decoded-key signals of the 4x4 keypad scanner.
// The scanner takes the slave modport; the keypad model or board glue takes master.
interface keypad_scanner_if;
  logic [3:0] filas;
  logic [3:0] columnas;
  logic [3:0] tecla;
  logic       tipo;
  logic       valida;
  logic       presionada;

  modport master (
    output filas,
    input  columnas, tecla, tipo, valida, presionada
  );

  modport slave (
    input  filas,
    output columnas, tecla, tipo, valida, presionada
  );
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 active-low keypad scanner: column scan, 2-FF row sync, press/release
// debounce, key encoding with a one-cycle strobe per accepted press.
module keypad_scanner #(
  parameter int SCAN_DIV     = 4,
  parameter int DEBOUNCE_CNT = 3
) (
  input  logic            clk,
  input  logic            rst,
  keypad_scanner_if.slave kp
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CNT_W = $clog2(DEBOUNCE_CNT + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CNT);

  typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD} state_e;

  state_e           state_q, state_d;
  logic [3:0]       sync_meta_q, fs_q;
  logic [DIV_W-1:0] div_q;
  logic [1:0]       col_q, col_d;
  logic [1:0]       row_q, row_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       tecla_q, tecla_d;
  logic             tipo_q, tipo_d;
  logic             valida_q, valida_d;
  logic             pres_q, pres_d;

  logic             sample;
  logic             any_low;
  logic [1:0]       low_row;
  logic             row_high;
  logic [CNT_W-1:0] cnt_inc;
  logic             scan_hit, deb_accept, deb_bounce, held_release;

  function automatic logic [4:0] key_code(input logic [1:0] r, input logic [1:0] c);
    // {tecla, tipo}
    case ({r, c})
      4'b00_00: key_code = {4'd1, 1'b1};
      4'b00_01: key_code = {4'd2, 1'b1};
      4'b00_10: key_code = {4'd3, 1'b1};
      4'b00_11: key_code = {4'd0, 1'b0};
      4'b01_00: key_code = {4'd4, 1'b1};
      4'b01_01: key_code = {4'd5, 1'b1};
      4'b01_10: key_code = {4'd6, 1'b1};
      4'b01_11: key_code = {4'd1, 1'b0};
      4'b10_00: key_code = {4'd7, 1'b1};
      4'b10_01: key_code = {4'd8, 1'b1};
      4'b10_10: key_code = {4'd9, 1'b1};
      4'b10_11: key_code = {4'd2, 1'b0};
      4'b11_00: key_code = {4'd7, 1'b0};
      4'b11_01: key_code = {4'd0, 1'b1};
      4'b11_10: key_code = {4'd6, 1'b0};
      default:  key_code = {4'd3, 1'b0};
    endcase
  endfunction

  assign sample   = (div_q == DIV_LAST);
  assign any_low  = ~&fs_q;
  assign row_high = fs_q[row_q];
  assign cnt_inc  = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
  assign low_row  = !fs_q[0] ? 2'd0 : !fs_q[1] ? 2'd1 : !fs_q[2] ? 2'd2 : 2'd3;

  assign scan_hit     = (state_q == SCAN)     && sample && any_low;
  assign deb_accept   = (state_q == DEBOUNCE) && (cnt_q == CNT_MAX);
  assign deb_bounce   = (state_q == DEBOUNCE) && !deb_accept && sample && row_high;
  assign held_release = (state_q == HELD)     && sample && row_high && (cnt_inc == CNT_MAX);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of process evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= SCAN;
      sync_meta_q <= 4'b1111;
      fs_q        <= 4'b1111;
      div_q       <= '0;
      col_q       <= 2'd0;
      row_q       <= 2'd0;
      cnt_q       <= '0;
      tecla_q     <= 4'd0;
      tipo_q      <= 1'b0;
      valida_q    <= 1'b0;
      pres_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync_meta_q <= kp.filas;
      fs_q        <= sync_meta_q;
      div_q       <= sample ? '0 : div_q + 1'b1;
      col_q       <= col_d;
      row_q       <= row_d;
      cnt_q       <= cnt_d;
      tecla_q     <= tecla_d;
      tipo_q      <= tipo_d;
      valida_q    <= valida_d;
      pres_q      <= pres_d;
    end
  end

  // NOTE: every always_comb output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      SCAN:     if (scan_hit)     state_d = DEBOUNCE;
      DEBOUNCE: if (deb_accept)   state_d = HELD;
                else if (deb_bounce) state_d = SCAN;
      HELD:     if (held_release) state_d = SCAN;
      default:  state_d = SCAN;
    endcase
  end

  always_comb begin
    col_d    = col_q;
    row_d    = row_q;
    cnt_d    = cnt_q;
    tecla_d  = tecla_q;
    tipo_d   = tipo_q;
    valida_d = 1'b0;
    pres_d   = pres_q;
    unique case (state_q)
      SCAN: if (sample) begin
        if (any_low) begin
          row_d = low_row;
          cnt_d = CNT_W'(1);
        end else begin
          col_d = col_q + 2'd1;
        end
      end
      DEBOUNCE: begin
        if (deb_accept) begin
          {tecla_d, tipo_d} = key_code(row_q, col_q);
          valida_d = 1'b1;
          pres_d   = 1'b1;
          cnt_d    = '0;
        end else if (deb_bounce) begin
          cnt_d = '0;
          col_d = col_q + 2'd1;
        end else if (sample) begin
          cnt_d = cnt_inc;
        end
      end
      HELD: if (sample) begin
        // Only the held key's row is watched; a low sample restarts the release count.
        if (held_release) begin
          pres_d = 1'b0;
          cnt_d  = '0;
          col_d  = col_q + 2'd1;
        end else if (row_high) begin
          cnt_d = cnt_inc;
        end else begin
          cnt_d = '0;
        end
      end
      default: ;
    endcase
  end

  assign kp.columnas   = ~(4'b0001 << col_q);
  assign kp.tecla      = tecla_q;
  assign kp.tipo       = tipo_q;
  assign kp.valida     = valida_q;
  assign kp.presionada = pres_q;

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Scans a 4x4 active-low matrix keypad, synchronizes and debounces it, and encodes each accepted press as a 4-bit key code plus a number/operator flag.
- Sits directly upstream of the 7-segment converter stage, which consumes the `tecla`/`tipo` pair.
- Emits a one-cycle `valida` strobe per accepted press for the calculator control logic.
- No auto-repeat: one strobe per physical press.

Parameters:
- SCAN_DIV, 4, clock cycles per column step; minimum 4, which covers synchronizer plus settling.
- DEBOUNCE_CNT, 3, consecutive identical samples needed to accept a press or a release; minimum 1.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- filas  in  4  keypad rows; active-low, pulled up externally.
- columnas  out  4  keypad column drive; active-low one-hot.
- tecla  out  4  key code of the last accepted key.
- tipo  out  1  1 = number, 0 = operator/control.
- valida  out  1  one-cycle pulse when `tecla`/`tipo` are updated.
- presionada  out  1  high while a key is accepted and not yet released.

Behaviour:
- Reset state:
  - columnas=4'b1110, tecla=0, tipo=0, valida=0, presionada=0.
  - div=0, state=SCAN, debounce counter=0, synchronizer flops=4'b1111.
- Input synchronization: `filas` passes through a 2-FF synchronizer; all logic uses the synchronized value `fs`.
- Sample timing:
  - Divider `div` counts 0..SCAN_DIV-1 and wraps; it runs in every state.
  - A "sample" is the cycle where div==SCAN_DIV-1.
  - Column index c (0..3) drives columnas = ~(1<<c).
- SCAN state:
  - At each sample, if any bit of fs is 0, latch (r,c) with r = lowest-index low row, set counter=1, and go to DEBOUNCE. Column does not advance.
  - Otherwise advance c = c+1 mod 4 at the same edge.
- DEBOUNCE state: column is frozen. At each sample:
  - fs[r]==0 → counter+1.
  - fs[r]==1 → return to SCAN, counter=0, advance c.
- Accepting a press:
  - When the counter reaches DEBOUNCE_CNT (DEBOUNCE_CNT=1 means accept on the detection sample), on the next edge: tecla/tipo updated, valida=1 for exactly one cycle, presionada=1, go to HELD.
  - Acceptance latency: one clock after the DEBOUNCE_CNT-th low sample.
- HELD state: column frozen, counter=0. At each sample:
  - fs[r]==1 → counter+1.
  - fs[r]==0 → counter=0.
  - Counter reaching DEBOUNCE_CNT → presionada=0, counter=0, advance c, go to SCAN.
  - Other keys pressed meanwhile are ignored.
- Output hold: tecla/tipo keep their value until the next acceptance.
- Multiple rows low in the detected column: lowest row index wins.
- Keys in other columns during DEBOUNCE/HELD: invisible (column frozen), so they are ignored.
- Key map (row r, column c → tecla,tipo):
  - r0: c0 1,1 | c1 2,1 | c2 3,1 | c3 plus 0,0
  - r1: c0 4,1 | c1 5,1 | c2 6,1 | c3 minus 1,0
  - r2: c0 7,1 | c1 8,1 | c2 9,1 | c3 mult 2,0
  - r3: c0 clear 7,0 | c1 0,1 | c2 equals 6,0 | c3 div 3,0
- Reset mid-operation: every state returns immediately to the reset values; no valida pulse is generated by reset.
- Width rules: div is clog2(SCAN_DIV) bits; the debounce counter is clog2(DEBOUNCE_CNT+1) bits and saturates at DEBOUNCE_CNT.

Test Plan (SCAN_DIV=4, DEBOUNCE_CNT=3):
- Reset, no key → columnas cycles 1110,1101,1011,0111, changing every 4 clocks; valida never asserts; tecla=0, tipo=0.
- Hold row1/col1 low (key "5") ≥ 20 cycles → exactly one valida pulse, tecla=5, tipo=1, presionada=1; on release ≥ 12 cycles, presionada=0 and scanning resumes from col2.
- Bounce: key "equals" (r3,c2) low for 1 sample then high → no valida, scan resumes; then held stable → tecla=6, tipo=0, one pulse.
- Rows 0 and 2 both low in col3 → tecla=0, tipo=0 (plus, row 0 wins); add "1" (r0,c0) while held → ignored, no extra pulse.
- Key held for 200 cycles → exactly one valida; release glitch of 2 samples high then low → presionada stays 1.
- Assert rst while in HELD with "clear" (r3,c0) held → outputs return to reset values at once; after rst drops with the key still held, a new acceptance gives tecla=7, tipo=0.
